// File: rtl/fb_pkg.sv
// Shared types and constants for the framebuffer rectangle-fill engine.
// Clipping to the visible screen is enabled by defining FB_FILL_CLIP_EN.
package fb_pkg;

  // Visible framebuffer size in pixels.
  localparam int unsigned SCREEN_W = 200;
  localparam int unsigned SCREEN_H = 150;

  // Fill sequencer states.
  typedef enum logic [1:0] {
    StIdle,
    StClip,
    StFill,
    StDone
  } fill_state_e;

  // One latched fill command.
  typedef struct packed {
    logic [7:0]  x0;
    logic [7:0]  y0;
    logic [7:0]  w;
    logic [7:0]  h;
    logic [23:0] color;
  } rect_cmd_t;

endpackage

// File: rtl/fb_rect_clip.sv
// Combinational clip calculator: exclusive end coordinates and an empty flag
// for a rectangle. With FB_FILL_CLIP_EN the rectangle is clipped to the
// visible screen; without it the ends wrap modulo 256 and only zero-sized
// rectangles are empty.
module fb_rect_clip (
  input  logic [7:0] x0,
  input  logic [7:0] y0,
  input  logic [7:0] w,
  input  logic [7:0] h,
  output logic [7:0] x_end,
  output logic [7:0] y_end,
  output logic       empty
);

  import fb_pkg::*;

`ifdef FB_FILL_CLIP_EN
  logic [8:0] x_sum;
  logic [8:0] y_sum;

  // 9-bit sums so a rectangle running past column 255 cannot wrap back on-screen.
  always_comb begin
    x_sum = {1'b0, x0} + {1'b0, w};
    y_sum = {1'b0, y0} + {1'b0, h};
    x_end = (x_sum > 9'(SCREEN_W)) ? 8'(SCREEN_W) : x_sum[7:0];
    y_end = (y_sum > 9'(SCREEN_H)) ? 8'(SCREEN_H) : y_sum[7:0];
    empty = (w == 8'd0) || (h == 8'd0) ||
            (x0 >= 8'(SCREEN_W)) || (y0 >= 8'(SCREEN_H));
  end
`else
  // Raw 8-bit ends; the cursor wraps with them so the pixel count stays w*h.
  always_comb begin
    x_end = x0 + w;
    y_end = y0 + h;
    empty = (w == 8'd0) || (h == 8'd0);
  end
`endif

endmodule

// File: rtl/fb_fill_engine.sv
// Rectangle-fill write generator feeding the VGA framebuffer write port.
// Accepts one command at a time and emits one registered pixel write per
// clock in row-major order. Screen clipping is built when FB_FILL_CLIP_EN
// is defined; otherwise coordinates wrap modulo 256.
module fb_fill_engine
  import fb_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [7:0]  cmd_x0,
  input  logic [7:0]  cmd_y0,
  input  logic [7:0]  cmd_w,
  input  logic [7:0]  cmd_h,
  input  logic [23:0] cmd_color,
  input  logic        abort,
  output logic        busy,
  output logic        done,
  output logic        fb_enable,
  output logic [15:0] xy_addr,
  output logic [23:0] color
);

  fill_state_e state_q, state_d;
  rect_cmd_t   cmd_q, cmd_d;
  logic [7:0]  x_q, x_d;
  logic [7:0]  y_q, y_d;
  logic [7:0]  x_end_q, x_end_d;
  logic [7:0]  y_end_q, y_end_d;
  logic        fb_enable_q, fb_enable_d;
  logic [15:0] xy_addr_q, xy_addr_d;
  logic [23:0] color_q, color_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;

  logic [7:0]  clip_x_end;
  logic [7:0]  clip_y_end;
  logic        clip_empty;
  logic [7:0]  x_inc;
  logic [7:0]  y_inc;

  fb_rect_clip u_clip (
    .x0    (cmd_q.x0),
    .y0    (cmd_q.y0),
    .w     (cmd_q.w),
    .h     (cmd_q.h),
    .x_end (clip_x_end),
    .y_end (clip_y_end),
    .empty (clip_empty)
  );

  assign cmd_ready = (state_q == StIdle);
  assign busy      = busy_q;
  assign done      = done_q;
  assign fb_enable = fb_enable_q;
  assign xy_addr   = xy_addr_q;
  assign color     = color_q;

  // Next-state and registered-output decode for the fill sequencer.
  always_comb begin
    state_d     = state_q;
    cmd_d       = cmd_q;
    x_d         = x_q;
    y_d         = y_q;
    x_end_d     = x_end_q;
    y_end_d     = y_end_q;
    fb_enable_d = 1'b0;
    xy_addr_d   = xy_addr_q;
    color_d     = color_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    x_inc       = x_q + 8'd1;
    y_inc       = y_q + 8'd1;

    unique case (state_q)
      StIdle: begin
        if (cmd_valid) begin
          cmd_d   = '{x0: cmd_x0, y0: cmd_y0, w: cmd_w, h: cmd_h, color: cmd_color};
          busy_d  = 1'b1;
          state_d = StClip;
        end
      end
      StClip: begin
        x_end_d = clip_x_end;
        y_end_d = clip_y_end;
        x_d     = cmd_q.x0;
        y_d     = cmd_q.y0;
        state_d = (abort || clip_empty) ? StDone : StFill;
      end
      StFill: begin
        if (abort) begin
          // Nothing is registered on the abort edge; the previous write stands.
          state_d = StDone;
        end else begin
          fb_enable_d = 1'b1;
          xy_addr_d   = {y_q, x_q};
          color_d     = cmd_q.color;
          if (x_inc == x_end_q) begin
            x_d = cmd_q.x0;
            y_d = y_inc;
            if (y_inc == y_end_q) begin
              state_d = StDone;
            end
          end else begin
            x_d = x_inc;
          end
        end
      end
      StDone: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State and output registers; synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      cmd_q       <= '0;
      x_q         <= 8'd0;
      y_q         <= 8'd0;
      x_end_q     <= 8'd0;
      y_end_q     <= 8'd0;
      fb_enable_q <= 1'b0;
      xy_addr_q   <= 16'd0;
      color_q     <= 24'd0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cmd_q       <= cmd_d;
      x_q         <= x_d;
      y_q         <= y_d;
      x_end_q     <= x_end_d;
      y_end_q     <= y_end_d;
      fb_enable_q <= fb_enable_d;
      xy_addr_q   <= xy_addr_d;
      color_q     <= color_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

endmodule

// File: tb/tb_fb_fill_engine.sv
// Self-checking bench for fb_fill_engine. A timeline model predicts the
// outputs after every clock edge from the pixel list of each command; the
// compare process checks the DUT on every falling edge. Directed tests pin
// the model with literal expectations, then a randomized phase follows.
// Clip-dependent expectations follow FB_FILL_CLIP_EN.
module tb_fb_fill_engine;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic [7:0]  cmd_x0 = 8'd0;
  logic [7:0]  cmd_y0 = 8'd0;
  logic [7:0]  cmd_w = 8'd0;
  logic [7:0]  cmd_h = 8'd0;
  logic [23:0] cmd_color = 24'd0;
  logic        abort = 1'b0;
  logic        cmd_ready;
  logic        busy;
  logic        done;
  logic        fb_enable;
  logic [15:0] xy_addr;
  logic [23:0] color;

  fb_fill_engine dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_x0    (cmd_x0),
    .cmd_y0    (cmd_y0),
    .cmd_w     (cmd_w),
    .cmd_h     (cmd_h),
    .cmd_color (cmd_color),
    .abort     (abort),
    .busy      (busy),
    .done      (done),
    .fb_enable (fb_enable),
    .xy_addr   (xy_addr),
    .color     (color)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Expected visible outputs after one clock edge.
  typedef struct {
    bit        en;
    bit [15:0] addr;
    bit [23:0] col;
    bit        bsy;
    bit        dn;
    bit        rdy;
    bit        abortable;  // edge on which abort ends the fill
  } step_t;

  step_t       tl[$];
  step_t       exp_s;
  bit          exp_rst = 1'b0;
  bit          have_exp = 1'b0;
  int unsigned cyc = 0;
  int unsigned acc_cyc = 0;
  int unsigned n_acc = 0;

  // DUT-observed logs for the literal checks.
  int unsigned wr_cyc[$];
  logic [15:0] wr_addr[$];
  logic [23:0] wr_col[$];
  int unsigned done_cyc[$];
  logic        done_rdy[$];

  function automatic step_t mk(bit en, bit [15:0] addr, bit [23:0] col, bit bsy, bit dn,
                               bit rdy, bit ab);
    step_t s;
    s.en = en; s.addr = addr; s.col = col; s.bsy = bsy; s.dn = dn; s.rdy = rdy;
    s.abortable = ab;
    return s;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, req);
    end
  endtask

  // Future outputs for a command accepted on the current edge: one decision
  // cycle, one write per on-screen pixel in row-major order, then done.
  task automatic build(input bit [7:0] x0, input bit [7:0] y0, input bit [7:0] w,
                       input bit [7:0] h, input bit [23:0] c);
    int xx;
    int yy;
    tl.push_back(mk(1'b0, 16'h0, 24'h0, 1'b1, 1'b0, 1'b0, 1'b1));
    for (int j = 0; j < int'(h); j++) begin
      for (int i = 0; i < int'(w); i++) begin
        xx = int'(x0) + i;
        yy = int'(y0) + j;
`ifdef FB_FILL_CLIP_EN
        if (xx < 200 && yy < 150)
          tl.push_back(mk(1'b1, {8'(yy), 8'(xx)}, c, 1'b1, 1'b0, 1'b0, 1'b1));
`else
        tl.push_back(mk(1'b1, {8'(yy % 256), 8'(xx % 256)}, c, 1'b1, 1'b0, 1'b0, 1'b1));
`endif
      end
    end
    tl.push_back(mk(1'b0, 16'h0, 24'h0, 1'b0, 1'b1, 1'b1, 1'b0));
  endtask

  // Reference model: advances one step per rising edge from sampled inputs.
  initial begin
    step_t e;
    forever begin
      @(posedge clk);
      cyc++;
      exp_rst = 1'b0;
      if (!reset_n) begin
        tl.delete();
        exp_s   = mk(1'b0, 16'h0, 24'h0, 1'b0, 1'b0, 1'b1, 1'b0);
        exp_rst = 1'b1;
      end else if (tl.size() == 0) begin
        if (cmd_valid) begin
          acc_cyc = cyc;
          n_acc++;
          build(cmd_x0, cmd_y0, cmd_w, cmd_h, cmd_color);
          exp_s = mk(1'b0, 16'h0, 24'h0, 1'b1, 1'b0, 1'b0, 1'b0);
        end else begin
          exp_s = mk(1'b0, 16'h0, 24'h0, 1'b0, 1'b0, 1'b1, 1'b0);
        end
      end else begin
        e = tl.pop_front();
        if (e.abortable && abort) begin
          tl.delete();
          exp_s = mk(1'b0, 16'h0, 24'h0, 1'b1, 1'b0, 1'b0, 1'b0);
          tl.push_back(mk(1'b0, 16'h0, 24'h0, 1'b0, 1'b1, 1'b1, 1'b0));
        end else begin
          exp_s = e;
        end
      end
      have_exp = 1'b1;
    end
  end

  // Compare process: DUT vs model on every falling edge, plus logging.
  initial begin
    forever begin
      @(negedge clk);
      if (have_exp) begin
        check("fb_enable", 32'(fb_enable), 32'(exp_s.en));
        check("busy", 32'(busy), 32'(exp_s.bsy));
        check("done", 32'(done), 32'(exp_s.dn));
        check("cmd_ready", 32'(cmd_ready), 32'(exp_s.rdy));
        if (exp_s.en || exp_rst) begin
          check("xy_addr", 32'(xy_addr), 32'(exp_s.addr));
          check("color", 32'(color), 32'(exp_s.col));
        end
      end
      if (fb_enable === 1'b1) begin
        wr_cyc.push_back(cyc);
        wr_addr.push_back(xy_addr);
        wr_col.push_back(color);
      end
      if (done === 1'b1) begin
        done_cyc.push_back(cyc);
        done_rdy.push_back(cmd_ready);
      end
    end
  end

  task automatic clear_logs();
    wr_cyc.delete(); wr_addr.delete(); wr_col.delete();
    done_cyc.delete(); done_rdy.delete();
  endtask

  // Present a command and return the accept edge; valid stays up if keep is set.
  task automatic send(input bit [7:0] x0, input bit [7:0] y0, input bit [7:0] w,
                      input bit [7:0] h, input bit [23:0] c, input bit keep,
                      output int unsigned t);
    int unsigned start = n_acc;
    int k = 0;
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_x0 = x0; cmd_y0 = y0; cmd_w = w; cmd_h = h; cmd_color = c;
    while (n_acc == start && k < 500) begin
      @(negedge clk);
      k++;
    end
    if (n_acc == start) check("accept_timeout", 32'd0, 32'd1);
    t = acc_cyc;
    if (!keep) cmd_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int k = 0;
    while (!(tl.size() == 0 && exp_s.rdy) && k < 3000) begin
      @(negedge clk);
      k++;
    end
    if (k >= 3000) check("idle_timeout", 32'd0, 32'd1);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    int unsigned t;
    int unsigned t2;
    int k;
    logic [15:0] basic_exp [6];
    basic_exp = '{16'h140A, 16'h140B, 16'h140C, 16'h150A, 16'h150B, 16'h150C};

    // Reset state.
    @(negedge clk);
    check("rst_fb_enable", 32'(fb_enable), 32'd0);
    check("rst_xy_addr", 32'(xy_addr), 32'd0);
    check("rst_color", 32'(color), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // Basic 3x2 fill.
    clear_logs();
    send(8'd10, 8'd20, 8'd3, 8'd2, 24'h00FF00, 1'b0, t);
    wait_idle();
    check("basic_count", 32'(wr_addr.size()), 32'd6);
    if (wr_addr.size() == 6) begin
      for (int i = 0; i < 6; i++) check("basic_addr", 32'(wr_addr[i]), 32'(basic_exp[i]));
      check("basic_color", 32'(wr_col[0]), 32'h00FF00);
      check("basic_first_cyc", wr_cyc[0] - t, 32'd2);
      check("basic_last_cyc", wr_cyc[5] - t, 32'd7);
    end
    check("basic_done_count", 32'(done_cyc.size()), 32'd1);
    if (done_cyc.size() == 1) check("basic_done_cyc", done_cyc[0] - t, 32'd8);

    // Right/bottom edge rectangle.
    clear_logs();
    send(8'd198, 8'd149, 8'd5, 8'd4, 24'h123456, 1'b0, t);
    wait_idle();
`ifdef FB_FILL_CLIP_EN
    check("clip_count", 32'(wr_addr.size()), 32'd2);
    if (wr_addr.size() == 2) begin
      check("clip_addr0", 32'(wr_addr[0]), 32'h95C6);
      check("clip_addr1", 32'(wr_addr[1]), 32'h95C7);
    end
    if (done_cyc.size() == 1) check("clip_done_cyc", done_cyc[0] - t, 32'd4);
    else check("clip_done_count", 32'(done_cyc.size()), 32'd1);
`else
    check("wrap_count", 32'(wr_addr.size()), 32'd20);
    if (wr_addr.size() == 20) begin
      check("wrap_first", 32'(wr_addr[0]), 32'h95C6);
      check("wrap_last", 32'(wr_addr[19]), 32'h98CA);
    end
    if (done_cyc.size() == 1) check("wrap_done_cyc", done_cyc[0] - t, 32'd22);
    else check("wrap_done_count", 32'(done_cyc.size()), 32'd1);
`endif

    // Zero width.
    clear_logs();
    send(8'd5, 8'd5, 8'd0, 8'd3, 24'hABCDEF, 1'b0, t);
    wait_idle();
    check("w0_count", 32'(wr_addr.size()), 32'd0);
    if (done_cyc.size() == 1) check("w0_done_cyc", done_cyc[0] - t, 32'd2);
    else check("w0_done_count", 32'(done_cyc.size()), 32'd1);

    // Start column at the screen width.
    clear_logs();
    send(8'd200, 8'd0, 8'd2, 8'd1, 24'h0000FF, 1'b0, t);
    wait_idle();
`ifdef FB_FILL_CLIP_EN
    check("x200_count", 32'(wr_addr.size()), 32'd0);
    if (done_cyc.size() == 1) check("x200_done_cyc", done_cyc[0] - t, 32'd2);
    else check("x200_done_count", 32'(done_cyc.size()), 32'd1);
`else
    check("x200_count", 32'(wr_addr.size()), 32'd2);
    if (wr_addr.size() == 2) check("x200_addr1", 32'(wr_addr[1]), 32'h00C9);
    if (done_cyc.size() == 1) check("x200_done_cyc", done_cyc[0] - t, 32'd4);
    else check("x200_done_count", 32'(done_cyc.size()), 32'd1);
`endif

    // Abort during the fifth visible write.
    clear_logs();
    send(8'd0, 8'd0, 8'd10, 8'd10, 24'h777777, 1'b0, t);
    while (cyc < t + 6) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    wait_idle();
    check("abort_count", 32'(wr_addr.size()), 32'd5);
    if (wr_addr.size() == 5) check("abort_last_addr", 32'(wr_addr[4]), 32'h0004);
    if (done_cyc.size() == 1) begin
      check("abort_done_cyc", done_cyc[0] - t, 32'd8);
      check("abort_ready", 32'(done_rdy[0]), 32'd1);
    end else check("abort_done_count", 32'(done_cyc.size()), 32'd1);

    // Second command held during a fill.
    clear_logs();
    send(8'd50, 8'd60, 8'd3, 8'd2, 24'h111111, 1'b1, t);
    cmd_x0 = 8'd100; cmd_y0 = 8'd100; cmd_w = 8'd2; cmd_h = 8'd2; cmd_color = 24'h222222;
    k = 0;
    while (n_acc == 0 || acc_cyc == t) begin
      if (k >= 200) break;
      @(negedge clk);
      k++;
    end
    t2 = acc_cyc;
    cmd_valid = 1'b0;
    wait_idle();
    check("bp_accept_cyc", t2 - t, 32'd9);
    check("bp_count", 32'(wr_addr.size()), 32'd10);
    check("bp_done_count", 32'(done_cyc.size()), 32'd2);
    if (wr_addr.size() == 10) begin
      check("bp_b_first_addr", 32'(wr_addr[6]), 32'h6464);
      check("bp_b_first_col", 32'(wr_col[6]), 32'h222222);
    end

    // Reset during a fill.
    clear_logs();
    send(8'd20, 8'd20, 8'd10, 8'd10, 24'h333333, 1'b0, t);
    while (cyc < t + 5) @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    check("mrst_fb_enable", 32'(fb_enable), 32'd0);
    check("mrst_busy", 32'(busy), 32'd0);
    check("mrst_done", 32'(done), 32'd0);
    reset_n = 1'b1;
    @(negedge clk);
    check("mrst_cmd_ready", 32'(cmd_ready), 32'd1);
    repeat (5) @(negedge clk);
    check("mrst_count", 32'(wr_addr.size()), 32'd4);
    check("mrst_no_done", 32'(done_cyc.size()), 32'd0);

    // Randomized traffic.
    for (int i = 0; i < 8000; i++) begin
      @(negedge clk);
      cmd_valid = ($urandom % 4) != 0;
      cmd_x0 = ($urandom % 2 == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(185, 215));
      cmd_y0 = ($urandom % 2 == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(135, 165));
      if ($urandom % 10 == 0) begin
        cmd_w = 8'($urandom_range(0, 255));
        cmd_h = 8'($urandom_range(0, 1));
      end else begin
        cmd_w = 8'($urandom_range(0, 12));
        cmd_h = 8'($urandom_range(0, 12));
      end
      cmd_color = 24'($urandom);
      abort = ($urandom % 40) == 0;
      reset_n = ($urandom % 1500) != 0;
    end
    @(negedge clk);
    cmd_valid = 1'b0;
    abort = 1'b0;
    reset_n = 1'b1;
    wait_idle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
